uart_tx_frame_ctrl: RTL
=======================

Name: uart_tx_frame_ctrl

Overview:
Parametrised UART transmit engine that merges the TX FSM, serializer, parity generator and output mux into one block. DATA_WIDTH is set at elaboration. Parity enable, parity type and stop-bit count are chosen per frame. Frames can be sent back-to-back with no idle gap. The block runs on the TX bit clock (one bit per clk cycle) and sits between the system register/FIFO read side and the UART TX pin.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
CNT_W, $clog2(DATA_WIDTH), width of the data-bit counter; derived, not overridden.

Ports:
clk  input  1  TX bit clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel payload, sampled on acceptance
D_Valid  input  1  payload valid request
PAR_En  input  1  1 = append parity bit; sampled on acceptance
PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance
STOP2  input  1  1 = two stop bits, 0 = one; sampled on acceptance
TX_OUT  output  1  serial line, registered, idles high
busy  output  1  registered, high while a frame is on the line
done  output  1  registered one-cycle pulse at frame completion

Behaviour:
- Reset (sync, active-high), sampled at a clk edge with reset=1:
  - state=IDLE, TX_OUT=1, busy=0, done=0; shift register and counters cleared.
  - Reset has priority over everything, including mid-frame. The line returns high on the same edge and the partial frame is dropped.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - State, TX_OUT and busy are registered together. TX_OUT always carries the bit of the current state.
- Acceptance: accept = D_Valid & (state==IDLE | last stop cycle).
  - Last stop cycle means STOP1 with the latched stop2=0, or STOP2.
  - On accept, latch P_DATA, PAR_En, PAR_TYP and STOP2. Compute parity from P_DATA: even = ^P_DATA, odd = ~^P_DATA.
  - D_Valid in any other cycle is ignored; no queuing.
- Transitions:
  - IDLE -> START on accept, else stay. TX_OUT=1, busy=0.
  - START -> DATA. TX_OUT=0, busy=1, bit counter=0.
  - DATA: TX_OUT = shift register LSB. Shift right each cycle. After DATA_WIDTH cycles (counter==DATA_WIDTH-1), go to PARITY if the latched par_en=1, else STOP1.
  - PARITY -> STOP1. TX_OUT = latched parity bit.
  - STOP1: TX_OUT=1. Go to STOP2 if the latched stop2=1. Otherwise go to START on accept, else IDLE.
  - STOP2: TX_OUT=1. Go to START on accept, else IDLE.
- Frame length: 1 + DATA_WIDTH + par_en + (1+stop2) cycles. Data is sent LSB first.
- busy:
  - Rises one cycle after the accept edge and stays 1 through the last stop bit.
  - On back-to-back accept it stays 1 continuously.
  - It falls only when state enters IDLE.
- done: high for exactly one cycle, in the cycle after the last stop bit. This holds whether the next state is IDLE or a back-to-back START.
- Config inputs changing mid-frame have no effect on the frame in flight.
- Unused/illegal state encodings go to IDLE with TX_OUT=1, busy=0.

Test Plan:
1. DATA_WIDTH=8, P_DATA=0xA5, PAR_En=0, STOP2=0, D_Valid pulsed 1 cycle in IDLE -> TX_OUT from the next cycle is 0,1,0,1,0,0,1,0,1,1. busy high for exactly 10 cycles. done pulses once in the 11th cycle. Line stays 1 afterwards.
2. P_DATA=0xA5, PAR_En=1, PAR_TYP=0 -> parity bit 0 after the 8 data bits, 11-cycle frame. Repeat with PAR_TYP=1 -> parity bit 1.
3. P_DATA=0x3C, PAR_En=1, PAR_TYP=1, STOP2=1 -> 12-cycle frame ending with parity 1 then 1,1. Toggling PAR_En/STOP2/P_DATA mid-frame leaves the frame unchanged.
4. D_Valid held high with 0x55 then 0xF0, no parity, 1 stop -> second START (0) immediately follows the first stop bit with no idle cycle. busy never drops across the 20 cycles. done pulses at cycle 11 and cycle 21.
5. Assert reset for 1 cycle during DATA bit 4 -> on the next edge TX_OUT=1, busy=0, done=0, state IDLE. A new D_Valid afterwards produces a clean full frame.
6. DATA_WIDTH=5, P_DATA=5'h13, PAR_En=1, PAR_TYP=0 -> 0,1,1,0,0,1,1(parity),1(stop). 8-cycle frame; busy high for 8 cycles.

Source files
------------

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit engine: start bit, LSB-first payload, optional parity, one or two stop bits.
// Frames chain back-to-back when a new request lands in the last stop cycle.
module uart_tx_frame_ctrl #(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  D_Valid,
  input  logic                  PAR_En,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  state_e                  r_state;
  logic                    r_tx;
  logic                    r_busy;
  logic                    r_done;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_par_en;
  logic                    r_par_bit;
  logic                    r_stop2;

  state_e                  w_next_state;
  logic                    w_last_stop;
  logic                    w_accept;
  logic                    w_tx_next;
  logic                    w_busy_next;
  logic                    w_done_next;
  logic [DATA_WIDTH-1:0]   w_shift_next;
  logic [CNT_W-1:0]        w_cnt_next;

  // Even parity is the XOR of the payload; odd parity is its complement.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  assign w_last_stop = ((r_state == S_STOP1) && !r_stop2) || (r_state == S_STOP2);
  assign w_accept    = D_Valid && ((r_state == S_IDLE) || w_last_stop);

  // State register together with the line, status flags and latched frame configuration
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_shift   <= {DATA_WIDTH{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_stop2   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_tx    <= w_tx_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_par_en  <= PAR_En;
        r_par_bit <= calc_parity(P_DATA, PAR_TYP);
        r_stop2   <= STOP2;
      end else begin
        r_par_en  <= r_par_en;
        r_par_bit <= r_par_bit;
        r_stop2   <= r_stop2;
      end
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_START;
        else          w_next_state = S_IDLE;
      end
      S_START: w_next_state = S_DATA;
      S_DATA: begin
        if (r_cnt != LAST_CNT) w_next_state = S_DATA;
        else if (r_par_en)     w_next_state = S_PARITY;
        else                   w_next_state = S_STOP1;
      end
      S_PARITY: w_next_state = S_STOP1;
      S_STOP1: begin
        if (r_stop2)       w_next_state = S_STOP2;
        else if (w_accept) w_next_state = S_START;
        else               w_next_state = S_IDLE;
      end
      S_STOP2: begin
        if (w_accept) w_next_state = S_START;
        else          w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so they register alongside it
  always_comb begin
    w_shift_next = r_shift;
    w_cnt_next   = {CNT_W{1'b0}};
    w_tx_next    = 1'b1;
    w_busy_next  = 1'b0;
    w_done_next  = w_last_stop;

    if (w_accept)                w_shift_next = P_DATA;
    else if (r_state == S_DATA)  w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};
    else                         w_shift_next = r_shift;

    if ((r_state == S_DATA) && (w_next_state == S_DATA)) w_cnt_next = r_cnt + CNT_W'(1'b1);
    else                                                  w_cnt_next = {CNT_W{1'b0}};

    case (w_next_state)
      S_IDLE:   w_tx_next = 1'b1;
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = r_par_bit;
      S_STOP1:  w_tx_next = 1'b1;
      S_STOP2:  w_tx_next = 1'b1;
      default:  w_tx_next = 1'b1;
    endcase

    if (w_next_state != S_IDLE) w_busy_next = 1'b1;
    else                        w_busy_next = 1'b0;
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
